// File: rtl/tone_pkg.sv
// Shared types and default tables for the tone sequencer.
package tone_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        PENDING = 2'd2
    } state_t;

    // Half-period counts for C4..C5 at a 100 MHz clock; entry [0] is C4.
    localparam logic [7:0][31:0] DEFAULT_HALF_TABLE = {
        32'd95557, 32'd101239, 32'd113636, 32'd127551,
        32'd143172, 32'd151686, 32'd170265, 32'd191110
    };

    // Half a second of beat at 100 MHz.
    localparam int DEFAULT_BEAT_HALF = 50_000_000;

endpackage

// File: rtl/beat_gen.sv
// Free-running beat square wave with a one-cycle tick at each rising beat.
module beat_gen #(
    parameter int BEAT_HALF = 50_000_000,
    parameter int BEAT_W    = 28
) (
    input  logic CLK,
    input  logic RESET,
    output logic BEAT_OUT,
    output logic BEAT_TICK
);

    if (BEAT_HALF < 2 || (64'(BEAT_HALF) >> BEAT_W) != 64'd0) begin : g_bad_beat
        $error("beat_gen: BEAT_HALF must be >= 2 and fit in BEAT_W bits");
    end

    logic [BEAT_W-1:0] cnt;

    // Count to BEAT_HALF-1, then wrap and flip the beat; tick marks the rise.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt       <= '0;
            BEAT_OUT  <= 1'b0;
            BEAT_TICK <= 1'b0;
        end else if (cnt == BEAT_W'(BEAT_HALF - 1)) begin
            cnt       <= '0;
            BEAT_OUT  <= ~BEAT_OUT;
            BEAT_TICK <= ~BEAT_OUT;
        end else begin
            cnt       <= cnt + BEAT_W'(1);
            BEAT_TICK <= 1'b0;
        end
    end

endmodule

// File: rtl/tone_seq_gen.sv
// Note sequencer: square-wave tone divider with glitch-free note changes,
// plus an independent beat generator.
// Optional feature: define TONE_OCTAVE_EN to add the 2-bit OCTAVE input.
module tone_seq_gen
    import tone_pkg::*;
#(
    parameter int NUM_NOTES = 8,
    parameter int DIV_W     = 18,
    parameter logic [NUM_NOTES-1:0][31:0] HALF_TABLE = DEFAULT_HALF_TABLE,
    parameter int BEAT_HALF = DEFAULT_BEAT_HALF,
    parameter int BEAT_W    = 28,
    localparam int SEL_W    = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [SEL_W-1:0] NOTE_SEL,
    input  logic             NOTE_VALID,
    output logic             NOTE_READY,
    input  logic             STOP,
`ifdef TONE_OCTAVE_EN
    input  logic [1:0]       OCTAVE,
`endif
    output logic             TONE_OUT,
    output logic             PLAYING,
    output logic             NOTE_ERR,
    output logic             BEAT_OUT,
    output logic             BEAT_TICK
);

`ifdef TONE_OCTAVE_EN
    // One extra bit so the doubled (lower-octave) divider always fits.
    localparam int CNT_W = DIV_W + 1;
`else
    localparam int CNT_W = DIV_W;
`endif

    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_chk
        if (HALF_TABLE[gi] < 32'd2 || (64'(HALF_TABLE[gi]) >> DIV_W) != 64'd0) begin : g_bad_half
            $error("tone_seq_gen: HALF_TABLE entry must be >= 2 and fit in DIV_W bits");
        end
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] half, half_n;
    logic [CNT_W-1:0] pend, pend_n;
    logic             tone, tone_n;
    logic             err, err_n;

    logic             sel_ok, accept, term;
    logic [SEL_W-1:0] idx;
    logic [DIV_W-1:0] base_half;
    logic [CNT_W-1:0] req_half;

    // An out-of-range index is still "accepted"; it only raises NOTE_ERR.
    assign sel_ok     = int'(NOTE_SEL) < NUM_NOTES;
    assign idx        = sel_ok ? NOTE_SEL : '0;
    assign base_half  = HALF_TABLE[idx][DIV_W-1:0];
    assign NOTE_READY = RESET | ((state != PENDING) & ~STOP);
    assign accept     = NOTE_VALID & NOTE_READY;
    assign term       = (cnt == half - CNT_W'(1));

`ifdef TONE_OCTAVE_EN
    // Octave scaling of the requested divider: 1 halves (floor 2), 2 doubles.
    always_comb begin
        req_half = {1'b0, base_half};
        case (OCTAVE)
            2'd1:    req_half = (base_half < DIV_W'(4)) ? CNT_W'(2)
                                                        : {2'b00, base_half[DIV_W-1:1]};
            2'd2:    req_half = {base_half, 1'b0};
            default: ;
        endcase
    end
`else
    assign req_half = base_half;
`endif

    // Next state: STOP overrides everything; a note change waits for the
    // current half-period to finish so no truncated half-period appears.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        half_n  = half;
        pend_n  = pend;
        tone_n  = tone;
        err_n   = 1'b0;
        if (STOP) begin
            state_n = IDLE;
            cnt_n   = '0;
            pend_n  = '0;
            tone_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && sel_ok) begin
                        half_n  = req_half;
                        cnt_n   = '0;
                        state_n = PLAY;
                    end
                end
                PLAY: begin
                    if (term) begin
                        tone_n = ~tone;
                        cnt_n  = '0;
                    end else begin
                        cnt_n  = cnt + CNT_W'(1);
                    end
                    if (accept && sel_ok) begin
                        pend_n  = req_half;
                        state_n = PENDING;
                    end
                end
                PENDING: begin
                    if (term) begin
                        tone_n  = ~tone;
                        cnt_n   = '0;
                        half_n  = pend;
                        state_n = PLAY;
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
            err_n = accept & ~sel_ok;
        end
    end

    // State register; reset aborts any tone immediately.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            half  <= '0;
            pend  <= '0;
            tone  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            half  <= half_n;
            pend  <= pend_n;
            tone  <= tone_n;
            err   <= err_n;
        end
    end

    assign TONE_OUT = tone;
    assign PLAYING  = (state != IDLE);
    assign NOTE_ERR = err;

    beat_gen #(
        .BEAT_HALF (BEAT_HALF),
        .BEAT_W    (BEAT_W)
    ) u_beat (
        .CLK       (CLK),
        .RESET     (RESET),
        .BEAT_OUT  (BEAT_OUT),
        .BEAT_TICK (BEAT_TICK)
    );

endmodule

// File: tb/tb_tone_seq_gen.sv
// Randomized scoreboard bench for tone_seq_gen (6 notes, halves 2..7, beat half 4).
module tb_tone_seq_gen;

    localparam int NN = 6;
    localparam int DW = 8;
    localparam int BH = 4;
    localparam int BW = 4;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] NOTE_SEL;
    logic       NOTE_VALID;
    logic       NOTE_READY;
    logic       STOP;
`ifdef TONE_OCTAVE_EN
    logic [1:0] OCTAVE;
`endif
    logic       TONE_OUT, PLAYING, NOTE_ERR, BEAT_OUT, BEAT_TICK;

    always #5 CLK = ~CLK;

    tone_seq_gen #(
        .NUM_NOTES  (NN),
        .DIV_W      (DW),
        .HALF_TABLE ({32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2}),
        .BEAT_HALF  (BH),
        .BEAT_W     (BW)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .NOTE_SEL   (NOTE_SEL),
        .NOTE_VALID (NOTE_VALID),
        .NOTE_READY (NOTE_READY),
        .STOP       (STOP),
`ifdef TONE_OCTAVE_EN
        .OCTAVE     (OCTAVE),
`endif
        .TONE_OUT   (TONE_OUT),
        .PLAYING    (PLAYING),
        .NOTE_ERR   (NOTE_ERR),
        .BEAT_OUT   (BEAT_OUT),
        .BEAT_TICK  (BEAT_TICK)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct { int c; bit v; } ev_t;
    ev_t tone_q[$];
    int  err_q[$];

    // Reference model: a tone is "next edge at cycle m_next", not a counter.
    bit m_play = 0, m_pend = 0, m_tone = 0;
    int m_next = 0, m_half = 0, m_phalf = 0;
    int rst_edge = 0;
    bit rst_seen = 0;
    int tbl[NN] = '{2, 3, 4, 5, 6, 7};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_half(input int sel, input int oct);
        int h;
        h = tbl[sel];
`ifdef TONE_OCTAVE_EN
        if (oct == 1) h = (h / 2 < 2) ? 2 : h / 2;
        else if (oct == 2) h = h * 2;
`endif
        return h;
    endfunction

    // Advance the model by one clock edge using the inputs that edge sampled.
    task automatic model_edge(input int oct);
        int  n;
        bit  rdy;
        ev_t e;
        n = cyc;
        if (RESET || STOP) begin
            if (m_tone) begin e.c = n; e.v = 1'b0; tone_q.push_back(e); end
            m_tone = 0; m_play = 0; m_pend = 0;
            if (RESET) begin rst_edge = n; rst_seen = 1; end
            return;
        end
        rdy = !m_pend;
        if (m_play && n == m_next) begin
            m_tone = !m_tone;
            e.c = n; e.v = m_tone; tone_q.push_back(e);
            if (m_pend) begin m_half = m_phalf; m_pend = 0; end
            m_next = n + m_half;
        end
        if (NOTE_VALID && rdy) begin
            if (int'(NOTE_SEL) >= NN) err_q.push_back(n);
            else if (!m_play) begin
                m_play = 1;
                m_half = exp_half(int'(NOTE_SEL), oct);
                m_next = n + m_half;
            end else begin
                m_pend  = 1;
                m_phalf = exp_half(int'(NOTE_SEL), oct);
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit stp, input bit vld, input int sel, input int oct);
        RESET      = rst;
        STOP       = stp;
        NOTE_VALID = vld;
        NOTE_SEL   = 3'(sel);
`ifdef TONE_OCTAVE_EN
        OCTAVE     = 2'(oct);
`endif
        #1;
        check("note_ready", NOTE_READY, rst | (!m_pend && !stp));
        @(posedge CLK);
        cyc++;
        model_edge(oct);
        @(negedge CLK);
    endtask

    // Monitor: pops expected tone edges / error pulses whenever the DUT shows one.
    logic prev_tone = 1'b0;
    always @(negedge CLK) begin
        int  k;
        ev_t e;
        if (rst_seen) begin
            if (TONE_OUT !== prev_tone) begin
                if (tone_q.size() == 0) begin
                    check("tone_unexpected_edge", TONE_OUT, prev_tone);
                end else begin
                    e = tone_q.pop_front();
                    check("tone_edge_cycle", cyc, e.c);
                    check("tone_level", TONE_OUT, e.v);
                end
            end
            if (tone_q.size() > 0 && tone_q[0].c < cyc) begin
                e = tone_q.pop_front();
                check("tone_missing_edge_cycle", cyc, e.c);
            end
            prev_tone = TONE_OUT;

            if (NOTE_ERR === 1'b1) begin
                if (err_q.size() == 0) check("note_err_unexpected", NOTE_ERR, 0);
                else check("note_err_cycle", cyc, err_q.pop_front());
            end
            if (err_q.size() > 0 && err_q[0] < cyc)
                check("note_err_missing_cycle", cyc, err_q.pop_front());

            check("playing", PLAYING, m_play);

            k = cyc - rst_edge;
            check("beat_out", BEAT_OUT, ((k / BH) % 2) == 1);
            check("beat_tick", BEAT_TICK, (k > 0) && (k % BH == 0) && ((k / BH) % 2 == 1));
        end
    end

    initial begin
        RESET = 1'b1; STOP = 1'b0; NOTE_VALID = 1'b0; NOTE_SEL = '0;
`ifdef TONE_OCTAVE_EN
        OCTAVE = '0;
`endif
        @(negedge CLK);
        repeat (3) cycle(1, 0, 0, 0, 0);
        check("rst_tone", TONE_OUT, 0);
        check("rst_beat_out", BEAT_OUT, 0);
        check("rst_beat_tick", BEAT_TICK, 0);
        check("rst_note_err", NOTE_ERR, 0);
        check("rst_playing", PLAYING, 0);
        check("rst_note_ready", NOTE_READY, 1);

        // Directed: start note 1, let it run, change note, then stop with a request.
        cycle(0, 0, 1, 1, 0);
        repeat (12) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 5, 0);
        cycle(0, 0, 1, 2, 0);
        cycle(0, 1, 1, 3, 0);
        repeat (10) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 7, 0);
        repeat (5) cycle(0, 0, 0, 0, 0);

        // Random traffic: notes, bad indices, stops and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 399) == 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7),
                  $urandom_range(0, 3));
        end
        repeat (20) cycle(0, 0, 0, 0, 0);

        check("tone_queue_drained", tone_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
